dmem_port_arbiter: RTL

- Shares the single data port of the instruction/data memory between two requesters: the core load/store unit (requester 0, "core") and the debug/program-loader master (requester 1, "dbg").
- Sits between the dbus interconnect and the memory's data port.
- Serialises transactions (one outstanding at a time), gives fixed priority to core, and bounds dbg starvation with a loss counter.
- Performs a word-range check so out-of-range accesses never reach the memory.

---
 rtl/dmem_arb_pkg.sv | 35 +++
 rtl/arb_prio_starve.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  localparam bit ARB_ID_CORE = 1'b0;
  localparam bit ARB_ID_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } type_arb_state_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ARB_AW-1:0]     addr;
    logic [ARB_DW-1:0]     wdata;
    logic [ARB_DW/8-1:0]   mask;
  } type_arb_req_s;

  typedef struct packed {
    logic                  ack;
    logic [ARB_DW-1:0]     rdata;
    logic                  err;
  } type_arb_rsp_s;

  // Saturating increment for the 4-bit starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// rtl/arb_prio_starve.sv - fixed-priority winner select with bounded dbg starvation
module arb_prio_starve
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic       grant_id,
  output logic       grant_valid
);

  localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_d;
  logic [3:0] wait_cnt_q;

  // Core wins by default; dbg wins when alone or after MAX_WAIT consecutive losses.
  always_comb begin
    grant_valid = arb_en && (req != 2'b00);
    grant_id    = ARB_ID_CORE;
    if (req[ARB_ID_DBG] && ((wait_cnt_q >= MAX_WAIT_W) || !req[ARB_ID_CORE])) begin
      grant_id = ARB_ID_DBG;
    end
  end

  // Count dbg losses to core while both contend; clear whenever dbg is granted.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_valid && (grant_id == ARB_ID_DBG)) begin
      wait_cnt_d = 4'd0;
    end else if (arb_en && (req == 2'b11)) begin
      wait_cnt_d = sat_inc4(wait_cnt_q);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the memory data port between core and dbg masters
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_WORDS = 256,
  parameter int MAX_WAIT  = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [AW-1:0]   core_addr_i,
  input  logic [DW-1:0]   core_wdata_i,
  input  logic [DW/8-1:0] core_mask_i,
  output logic            core_ack_o,
  output logic [DW-1:0]   core_rdata_o,
  output logic            core_err_o,

  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic [DW-1:0]   dbg_wdata_i,
  input  logic [DW/8-1:0] dbg_mask_i,
  output logic            dbg_ack_o,
  output logic [DW-1:0]   dbg_rdata_o,
  output logic            dbg_err_o,

  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-3:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_mask_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam logic [AW-3:0] MEM_WORDS_W = (AW-2)'(MEM_WORDS);

  type_arb_state_e state_d, state_q;

  logic            cmd_id_d,    cmd_id_q;
  logic            cmd_we_d,    cmd_we_q;
  logic [AW-3:0]   cmd_addr_d,  cmd_addr_q;
  logic [DW-1:0]   cmd_wdata_d, cmd_wdata_q;
  logic [DW/8-1:0] cmd_mask_d,  cmd_mask_q;
  logic            cmd_oor_d,   cmd_oor_q;

  logic            arb_en;
  logic            grant_id;
  logic            grant_valid;
  logic [AW-3:0]   win_addr;

  // Byte-offset bits are never used: the memory port is word addressed.
  logic            unused_byte_offs;
  assign unused_byte_offs = ^{core_addr_i[1:0], dbg_addr_i[1:0]};

  assign arb_en = (state_q == IDLE);

  arb_prio_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({dbg_req_i, core_req_i}),
    .arb_en      (arb_en),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign win_addr = (grant_id == ARB_ID_DBG) ? dbg_addr_i[AW-1:2] : core_addr_i[AW-1:2];

  // Sequencing IDLE -> ISSUE -> RESP and capture of the granted command.
  always_comb begin
    state_d     = state_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_mask_d  = cmd_mask_q;
    cmd_oor_d   = cmd_oor_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          cmd_id_d    = grant_id;
          cmd_addr_d  = win_addr;
          cmd_oor_d   = (win_addr >= MEM_WORDS_W);
          if (grant_id == ARB_ID_DBG) begin
            cmd_we_d    = dbg_we_i;
            cmd_wdata_d = dbg_wdata_i;
            cmd_mask_d  = dbg_mask_i;
          end else begin
            cmd_we_d    = core_we_i;
            cmd_wdata_d = core_wdata_i;
            cmd_mask_d  = core_mask_i;
          end
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and command registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_id_q    <= ARB_ID_CORE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_mask_q  <= '0;
      cmd_oor_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_mask_q  <= cmd_mask_d;
      cmd_oor_q   <= cmd_oor_d;
    end
  end

  // Memory strobe only in ISSUE for in-range commands; mask is meaningless on reads.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_mask_o  = '0;
    if ((state_q == ISSUE) && !cmd_oor_q) begin
      mem_req_o   = 1'b1;
      mem_we_o    = cmd_we_q;
      mem_addr_o  = cmd_addr_q;
      mem_wdata_o = cmd_wdata_q;
      mem_mask_o  = cmd_we_q ? cmd_mask_q : '0;
    end
  end

  // Route the single-cycle response in RESP to whichever requester was granted.
  always_comb begin
    core_ack_o   = 1'b0;
    core_rdata_o = '0;
    core_err_o   = 1'b0;
    dbg_ack_o    = 1'b0;
    dbg_rdata_o  = '0;
    dbg_err_o    = 1'b0;
    if (state_q == RESP) begin
      if (cmd_id_q == ARB_ID_DBG) begin
        dbg_ack_o   = 1'b1;
        dbg_err_o   = cmd_oor_q;
        dbg_rdata_o = (!cmd_we_q && !cmd_oor_q) ? mem_rdata_i : '0;
      end else begin
        core_ack_o   = 1'b1;
        core_err_o   = cmd_oor_q;
        core_rdata_o = (!cmd_we_q && !cmd_oor_q) ? mem_rdata_i : '0;
      end
    end
  end

endmodule
